// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop sequencer for a 2-bit PWM duty select: steps one level
// per dwell period toward an accepted target, owns the output enable, and aborts at once.
module pwm_ramp_ctrl #(
  parameter int DWELL_CYCLES = 500000,
  parameter int DWELL_W      = 20
) (
  input  logic       clock_50mhz,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_target,
  output logic       cmd_ready,
  input  logic       abort,
  output logic [1:0] duty_cycle,
  output logic       pwm_enable,
  output logic       busy,
  output logic       done
);

  typedef enum logic {IDLE, RAMP} state_t;

  localparam logic [DWELL_W-1:0] DWELL_RELOAD = DWELL_W'(DWELL_CYCLES - 1);

  state_t             state_reg;
  logic [DWELL_W-1:0] dwell_reg;
  logic [1:0]         target_reg;
  logic [1:0]         start_level;
  logic [1:0]         step_level;

  assign cmd_ready = (state_reg == IDLE) & ~abort;

  // A disabled output always restarts the ramp from the lowest level.
  always_comb begin
    start_level = pwm_enable ? duty_cycle : 2'd0;
  end

  // Direction is re-evaluated on every step; saturates at both ends.
  always_comb begin
    step_level = duty_cycle;
    if (target_reg > duty_cycle && duty_cycle != 2'd3) begin
      step_level = duty_cycle + 2'd1;
    end else if (target_reg < duty_cycle && duty_cycle != 2'd0) begin
      step_level = duty_cycle - 2'd1;
    end
  end

  always_ff @(posedge clock_50mhz) begin
    if (reset || abort) begin
      state_reg  <= IDLE;
      duty_cycle <= 2'd0;
      pwm_enable <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dwell_reg  <= '0;
      target_reg <= 2'd0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            pwm_enable <= 1'b1;
            duty_cycle <= start_level;
            if (cmd_target == start_level) begin
              done <= 1'b1;
            end else begin
              target_reg <= cmd_target;
              dwell_reg  <= DWELL_RELOAD;
              state_reg  <= RAMP;
              busy       <= 1'b1;
            end
          end
        end
        RAMP: begin
          if (dwell_reg != '0) begin
            dwell_reg <= dwell_reg - 1'b1;
          end else begin
            duty_cycle <= step_level;
            if (step_level == target_reg) begin
              state_reg <= IDLE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              dwell_reg <= DWELL_RELOAD;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl with a 4-cycle dwell; one task per scenario.
module tb_pwm_ramp_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd_target;
  logic       cmd_ready;
  logic       abort;
  logic [1:0] duty_cycle;
  logic       pwm_enable;
  logic       busy;
  logic       done;

  int check_cnt = 0;
  int pass_cnt  = 0;

  pwm_ramp_ctrl #(.DWELL_CYCLES(4), .DWELL_W(4)) dut (
    .clock_50mhz(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_target(cmd_target),
    .cmd_ready(cmd_ready),
    .abort(abort),
    .duty_cycle(duty_cycle),
    .pwm_enable(pwm_enable),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_target = 2'd0; abort = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_cnt++;
    if ({duty_cycle, pwm_enable, busy, done, cmd_ready} !== 6'b000001)
      $display("FAIL reset: duty=%0d en=%b busy=%b done=%b ready=%b, want 0 0 0 0 1",
               duty_cycle, pwm_enable, busy, done, cmd_ready);
    else pass_cnt++;
    $display("reset: duty=%0d en=%b busy=%b done=%b ready=%b", duty_cycle, pwm_enable, busy, done, cmd_ready);
  endtask

  // Accepts a nonzero-length ramp and follows it edge by edge.
  task automatic run_ramp(input string name, input int from, input int to, input int steps);
    int exp_duty;
    int done_cnt;
    done_cnt = 0;
    cmd_valid = 1'b1; cmd_target = 2'(to);
    #1;
    check_cnt++;
    if (cmd_ready !== 1'b1) $display("FAIL %s ready_before: got %b want 1", name, cmd_ready);
    else pass_cnt++;
    tick();
    cmd_valid = 1'b0;
    check_cnt++;
    if ({pwm_enable, busy, done} !== 3'b110 || duty_cycle !== 2'(from) || cmd_ready !== 1'b0)
      $display("FAIL %s accept: en=%b busy=%b done=%b duty=%0d ready=%b want 1 1 0 %0d 0",
               name, pwm_enable, busy, done, duty_cycle, cmd_ready, from);
    else pass_cnt++;
    for (int k = 1; k <= steps * 4; k++) begin
      tick();
      exp_duty = (to > from) ? from + k / 4 : from - k / 4;
      if (done === 1'b1) done_cnt++;
      check_cnt++;
      if (duty_cycle !== 2'(exp_duty) || busy !== (k < steps * 4) || done !== (k == steps * 4) ||
          pwm_enable !== 1'b1 || cmd_ready !== (k == steps * 4))
        $display("FAIL %s edge+%0d: duty=%0d busy=%b done=%b en=%b ready=%b want duty=%0d busy=%b done=%b en=1 ready=%b",
                 name, k, duty_cycle, busy, done, pwm_enable, cmd_ready, exp_duty,
                 k < steps * 4, k == steps * 4, k == steps * 4);
      else pass_cnt++;
    end
    tick();
    if (done === 1'b1) done_cnt++;
    check_cnt++;
    if (done_cnt != 1 || duty_cycle !== 2'(to))
      $display("FAIL %s done_count: pulses=%0d duty=%0d want 1 %0d", name, done_cnt, duty_cycle, to);
    else pass_cnt++;
    $display("%s: %0d->%0d final duty=%0d done pulses=%0d", name, from, to, duty_cycle, done_cnt);
  endtask

  task automatic test_ramp_up();
    run_ramp("ramp_up", 0, 3, 3);
  endtask

  task automatic test_ramp_down();
    run_ramp("ramp_down", 3, 1, 2);
  endtask

  task automatic test_zero_length();
    run_ramp("ramp_1_to_2", 1, 2, 1);
    cmd_valid = 1'b1; cmd_target = 2'd2;
    tick();
    cmd_valid = 1'b0;
    check_cnt++;
    if ({busy, done, pwm_enable} !== 3'b011 || duty_cycle !== 2'd2)
      $display("FAIL zero_len pulse: busy=%b done=%b en=%b duty=%0d want 0 1 1 2",
               busy, done, pwm_enable, duty_cycle);
    else pass_cnt++;
    tick();
    check_cnt++;
    if ({busy, done} !== 2'b00 || duty_cycle !== 2'd2)
      $display("FAIL zero_len after: busy=%b done=%b duty=%0d want 0 0 2", busy, done, duty_cycle);
    else pass_cnt++;
    $display("zero_len: duty=%0d busy=%b done=%b", duty_cycle, busy, done);
  endtask

  task automatic test_abort();
    int done_cnt;
    done_cnt = 0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_cnt++;
    if ({pwm_enable, duty_cycle} !== 3'b000)
      $display("FAIL abort_idle: en=%b duty=%0d want 0 0", pwm_enable, duty_cycle);
    else pass_cnt++;
    cmd_valid = 1'b1; cmd_target = 2'd3;
    tick();
    cmd_valid = 1'b0;
    repeat (5) tick();
    check_cnt++;
    if (duty_cycle !== 2'd1 || busy !== 1'b1)
      $display("FAIL abort_pre: duty=%0d busy=%b want 1 1", duty_cycle, busy);
    else pass_cnt++;
    abort = 1'b1; cmd_valid = 1'b1; cmd_target = 2'd3;
    #1;
    check_cnt++;
    if (cmd_ready !== 1'b0) $display("FAIL abort_ready_low: got %b want 0", cmd_ready);
    else pass_cnt++;
    tick();
    abort = 1'b0; cmd_valid = 1'b0;
    #1;
    check_cnt++;
    if ({duty_cycle, pwm_enable, busy, done, cmd_ready} !== 6'b000001)
      $display("FAIL abort_shutdown: duty=%0d en=%b busy=%b done=%b ready=%b want 0 0 0 0 1",
               duty_cycle, pwm_enable, busy, done, cmd_ready);
    else pass_cnt++;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1 || pwm_enable === 1'b1) done_cnt++;
    end
    check_cnt++;
    if (done_cnt != 0)
      $display("FAIL abort_quiet: activity cycles=%0d want 0", done_cnt);
    else pass_cnt++;
    $display("abort: duty=%0d en=%b busy=%b stray=%0d", duty_cycle, pwm_enable, busy, done_cnt);
  endtask

  task automatic test_back_to_back();
    int done_cnt;
    int exp_duty;
    done_cnt = 0;
    cmd_valid = 1'b1; cmd_target = 2'd3;
    tick();
    cmd_target = 2'd0;  // second command held through the whole ramp
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (done === 1'b1) done_cnt++;
      check_cnt++;
      if (duty_cycle !== 2'(k / 4) || busy !== (k < 12) || cmd_ready !== (k == 12))
        $display("FAIL b2b_stall edge+%0d: duty=%0d busy=%b ready=%b want %0d %b %b",
                 k, duty_cycle, busy, cmd_ready, k / 4, k < 12, k == 12);
      else pass_cnt++;
    end
    tick();
    cmd_valid = 1'b0;
    if (done === 1'b1) done_cnt++;
    check_cnt++;
    if (busy !== 1'b1 || duty_cycle !== 2'd3 || done !== 1'b0)
      $display("FAIL b2b_accept: busy=%b duty=%0d done=%b want 1 3 0", busy, duty_cycle, done);
    else pass_cnt++;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_duty = 3 - k / 4;
      if (done === 1'b1) done_cnt++;
      check_cnt++;
      if (duty_cycle !== 2'(exp_duty) || busy !== (k < 12))
        $display("FAIL b2b_descend edge+%0d: duty=%0d busy=%b want %0d %b",
                 k, duty_cycle, busy, exp_duty, k < 12);
      else pass_cnt++;
    end
    tick();
    if (done === 1'b1) done_cnt++;
    check_cnt++;
    if (done_cnt != 2 || duty_cycle !== 2'd0 || pwm_enable !== 1'b1)
      $display("FAIL b2b_done_count: pulses=%0d duty=%0d en=%b want 2 0 1", done_cnt, duty_cycle, pwm_enable);
    else pass_cnt++;
    $display("back_to_back: final duty=%0d done pulses=%0d", duty_cycle, done_cnt);
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_zero_length();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
